vxe_vpu_rf_wr_arb: RTL

//  Single write-port scheduler for the VPU thread register files (vxe_vpu_thread_rf, one per thread).

---
 rtl/vxe_vpu_rf_wr_arb_if.sv | 34 +++
 rtl/vxe_vpu_rf_wr_arb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/vxe_vpu_rf_wr_arb_if.sv
// Bus between the VPU dispatcher / FMAC writeback requesters and the thread RF write-port arbiter.
interface vxe_vpu_rf_wr_arb_if #(
    parameter int NTHR      = 8,
    parameter int THR_IDX_W = 3
);
    logic                 cmd_valid;
    logic                 cmd_ready;
    logic [1:0]           cmd_op;
    logic [THR_IDX_W-1:0] cmd_thr;
    logic [2:0]           cmd_ridx;
    logic [37:0]          cmd_data;

    logic                 wb_valid;
    logic                 wb_ready;
    logic [THR_IDX_W-1:0] wb_thr;
    logic [31:0]          wb_data;

    logic [NTHR-1:0]      rf_wr_en;
    logic [2:0]           rf_ridx;
    logic [37:0]          rf_data;
    logic                 idle;

    modport master (
        output cmd_valid, cmd_op, cmd_thr, cmd_ridx, cmd_data,
        output wb_valid, wb_thr, wb_data,
        input  cmd_ready, wb_ready, rf_wr_en, rf_ridx, rf_data, idle
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_thr, cmd_ridx, cmd_data,
        input  wb_valid, wb_thr, wb_data,
        output cmd_ready, wb_ready, rf_wr_en, rf_ridx, rf_data, idle
    );
endinterface

// File: rtl/vxe_vpu_rf_wr_arb.sv
// Single write-port scheduler for the per-thread VPU register files: dispatcher commands,
// FMAC accumulator writebacks and a 3-cycle ACC/VL/EN clear sequence share one registered bus.
module vxe_vpu_rf_wr_arb #(
    parameter int NTHR          = 8,
    parameter int THR_IDX_W     = 3,
    parameter int MAX_WB_STREAK = 4
) (
    input logic                clk,
    input logic                nrst,
    vxe_vpu_rf_wr_arb_if.slave bus
);
    localparam logic [2:0] VPU_REG_IDX_ACC = 3'd1;
    localparam logic [2:0] VPU_REG_IDX_VL  = 3'd2;
    localparam logic [2:0] VPU_REG_IDX_EN  = 3'd3;

    localparam int              STK_W   = $clog2(MAX_WB_STREAK + 1);
    localparam logic [STK_W-1:0] STK_MAX = STK_W'(MAX_WB_STREAK);
    localparam logic [NTHR-1:0]  ALL_THR = '1;
    localparam logic [NTHR-1:0]  ONE_THR = NTHR'(1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_CLR_ACC,
        ST_CLR_VL,
        ST_CLR_EN
    } state_e;

    typedef enum logic [1:0] {
        OP_SINGLE = 2'd0,
        OP_BCAST  = 2'd1,
        OP_CLEAR  = 2'd2,
        OP_RSVD   = 2'd3
    } op_e;

    state_e           state_q, state_d;
    logic [STK_W-1:0] streak_q, streak_d;
    logic [NTHR-1:0]  rf_wr_en_q, rf_wr_en_d;
    logic [2:0]       rf_ridx_q, rf_ridx_d;
    logic [37:0]      rf_data_q, rf_data_d;

    logic in_idle, streak_sat;
    logic cmd_rdy, wb_rdy, cmd_gnt, wb_gnt;

    always_comb begin
        in_idle    = (state_q == ST_IDLE);
        streak_sat = (streak_q == STK_MAX);
        wb_rdy     = in_idle && !(bus.cmd_valid && streak_sat);
        cmd_rdy    = in_idle && (!bus.wb_valid || streak_sat);
        wb_gnt     = bus.wb_valid && wb_rdy;
        cmd_gnt    = bus.cmd_valid && cmd_rdy;

        state_d    = state_q;
        streak_d   = streak_q;
        rf_wr_en_d = '0;
        rf_ridx_d  = rf_ridx_q;
        rf_data_d  = rf_data_q;

        if (cmd_gnt || !bus.cmd_valid) begin
            streak_d = '0;
        end else if (wb_gnt && !streak_sat) begin
            streak_d = streak_q + 1'b1;
        end

        // Outputs are registered, so each CLR_x state is entered together with its own
        // clear write and meanwhile prepares the write of the following state.
        case (state_q)
            ST_IDLE: begin
                if (wb_gnt) begin
                    rf_wr_en_d = ONE_THR << bus.wb_thr;
                    rf_ridx_d  = VPU_REG_IDX_ACC;
                    rf_data_d  = {6'b0, bus.wb_data};
                end else if (cmd_gnt) begin
                    case (op_e'(bus.cmd_op))
                        OP_SINGLE: begin
                            if (int'(bus.cmd_thr) < NTHR) begin
                                rf_wr_en_d = ONE_THR << bus.cmd_thr;
                            end
                            rf_ridx_d = bus.cmd_ridx;
                            rf_data_d = bus.cmd_data;
                        end
                        OP_BCAST: begin
                            rf_wr_en_d = ALL_THR;
                            rf_ridx_d  = bus.cmd_ridx;
                            rf_data_d  = bus.cmd_data;
                        end
                        OP_CLEAR: begin
                            rf_wr_en_d = ALL_THR;
                            rf_ridx_d  = VPU_REG_IDX_ACC;
                            rf_data_d  = '0;
                            state_d    = ST_CLR_ACC;
                        end
                        OP_RSVD: begin
                        end
                    endcase
                end
            end
            ST_CLR_ACC: begin
                rf_wr_en_d = ALL_THR;
                rf_ridx_d  = VPU_REG_IDX_VL;
                rf_data_d  = '0;
                state_d    = ST_CLR_VL;
            end
            ST_CLR_VL: begin
                rf_wr_en_d = ALL_THR;
                rf_ridx_d  = VPU_REG_IDX_EN;
                rf_data_d  = '0;
                state_d    = ST_CLR_EN;
            end
            ST_CLR_EN: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q    <= ST_IDLE;
            streak_q   <= '0;
            rf_wr_en_q <= '0;
            rf_ridx_q  <= '0;
            rf_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            streak_q   <= streak_d;
            rf_wr_en_q <= rf_wr_en_d;
            rf_ridx_q  <= rf_ridx_d;
            rf_data_q  <= rf_data_d;
        end
    end

    assign bus.cmd_ready = cmd_rdy;
    assign bus.wb_ready  = wb_rdy;
    assign bus.rf_wr_en  = rf_wr_en_q;
    assign bus.rf_ridx   = rf_ridx_q;
    assign bus.rf_data   = rf_data_q;
    assign bus.idle      = (state_q == ST_IDLE) && (rf_wr_en_q == '0);
endmodule
